seq_code_lock: RTL and testbench

Parametrised serial code lock for the home-automation top level, the next generation of the fixed three-bit "110" door lock. It accepts code bits one per qualified strobe, frames them into a fixed-length entry, and compares each complete entry against a parameter code. A match holds the unlock output for a programmable time. Repeated mismatches trigger a timed lockout, and stalled entries are discarded by an inter-bit timeout.

---
 rtl/seq_code_lock.sv | 128 ++++++++++++
 tb/tb_seq_code_lock.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_code_lock.sv
// Serial code lock: frames CODE_LEN bits per entry, unlocks on match, locks out after MAX_TRIES misses.
// Unlock is registered on the edge accepting the last bit; partial entries expire after TIMEOUT_CYC idle cycles.
module seq_code_lock #(
    parameter int                  CODE_LEN    = 3,
    parameter logic [CODE_LEN-1:0] CODE        = 3'b110,
    parameter int                  OPEN_CYC    = 8,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCKOUT_CYC = 16,
    parameter int                  TIMEOUT_CYC = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in,
    input  logic                           in_valid,
    input  logic                           relock,
    output logic                           out,
    output logic                           lockout,
    output logic                           busy,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);
    localparam int BW   = $clog2(CODE_LEN + 1);
    localparam int IW   = $clog2(TIMEOUT_CYC + 1);
    localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, OPEN, LOCK} state_t;

    state_t              state, state_nxt;
    logic [CODE_LEN-1:0] shift_reg, shift_nxt;
    logic [BW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [IW-1:0]       idle_cnt, idle_nxt;
    logic [TW-1:0]       tmr, tmr_nxt;
    logic [FW-1:0]       fail_nxt;
    logic                out_nxt, lockout_nxt;
    logic [CODE_LEN:0]   shift_ext;
    logic [CODE_LEN-1:0] entry;

    // Extending by one bit keeps the slice legal even when CODE_LEN is 1.
    assign shift_ext = {shift_reg, in};
    assign entry     = shift_ext[CODE_LEN-1:0];
    assign busy      = (bit_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            tmr       <= '0;
            fail_cnt  <= '0;
            out       <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            idle_cnt  <= idle_nxt;
            tmr       <= tmr_nxt;
            fail_cnt  <= fail_nxt;
            out       <= out_nxt;
            lockout   <= lockout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        idle_nxt    = idle_cnt;
        tmr_nxt     = tmr;
        fail_nxt    = fail_cnt;
        out_nxt     = out;
        lockout_nxt = lockout;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shift_nxt = entry;
                    idle_nxt  = '0;
                    if (bit_cnt == BW'(CODE_LEN - 1)) begin
                        bit_cnt_nxt = '0;
                        if (entry == CODE) begin
                            state_nxt = OPEN;
                            out_nxt   = 1'b1;
                            fail_nxt  = '0;
                            tmr_nxt   = TW'(OPEN_CYC - 1);
                        end else if (int'(fail_cnt) + 1 < MAX_TRIES) begin
                            fail_nxt = fail_cnt + 1'b1;
                        end else begin
                            state_nxt   = LOCK;
                            lockout_nxt = 1'b1;
                            fail_nxt    = FW'(MAX_TRIES);
                            tmr_nxt     = TW'(LOCKOUT_CYC - 1);
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else if (busy) begin
                    // Only stalled partial entries age; an empty IDLE never expires.
                    if (idle_cnt == IW'(TIMEOUT_CYC - 1)) begin
                        bit_cnt_nxt = '0;
                        idle_nxt    = '0;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            OPEN: begin
                if (relock || tmr == '0) begin
                    state_nxt = IDLE;
                    out_nxt   = 1'b0;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            LOCK: begin
                if (tmr == '0) begin
                    state_nxt   = IDLE;
                    lockout_nxt = 1'b0;
                    fail_nxt    = '0;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_code_lock.sv
// Directed bench for seq_code_lock: vector table for match/lockout/recovery, hand sequences for
// timeout, asynchronous reset and a 5-bit code variant.
module tb_seq_code_lock;
    logic       clk = 1'b0;
    logic       rst;
    logic       in, in_valid, relock;
    logic       out, lockout, busy;
    logic [1:0] fail_cnt;
    logic       in5, v5, rl5;
    logic       out5, lockout5, busy5;
    logic [1:0] fail5;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       in;
        logic       vld;
        logic       rl;
        logic       e_out;
        logic       e_lock;
        logic       e_busy;
        logic [1:0] e_fail;
    } vec_t;

    vec_t tbl[$];

    seq_code_lock dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .relock(relock),
        .out(out), .lockout(lockout), .busy(busy), .fail_cnt(fail_cnt)
    );

    seq_code_lock #(.CODE_LEN(5), .CODE(5'b10110), .OPEN_CYC(2)) dut5 (
        .clk(clk), .rst(rst), .in(in5), .in_valid(v5), .relock(rl5),
        .out(out5), .lockout(lockout5), .busy(busy5), .fail_cnt(fail5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic b, input logic v, input logic r,
                                input logic eo, input logic el, input logic eb, input logic [1:0] ef);
        vec_t x;
        x.in = b; x.vld = v; x.rl = r;
        x.e_out = eo; x.e_lock = el; x.e_busy = eb; x.e_fail = ef;
        tbl.push_back(x);
    endfunction

    task automatic step(input logic b, input logic v, input logic r);
        in = b; in_valid = v; relock = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step5(input logic b, input logic v);
        in5 = b; v5 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic eo, input logic el, input logic eb, input logic [1:0] ef);
        check({tag, " out"}, 8'(out), 8'(eo));
        check({tag, " lockout"}, 8'(lockout), 8'(el));
        check({tag, " busy"}, 8'(busy), 8'(eb));
        check({tag, " fail_cnt"}, 8'(fail_cnt), 8'(ef));
    endtask

    // Called at posedge+1: reset asserts and is checked well before the next edge.
    task automatic rst_pulse(input string tag);
        #2 rst = 1'b1;
        #1 check_all(tag, 1'b0, 1'b0, 1'b0, 2'd0);
        #2 rst = 1'b0;
    endtask

    initial begin
        // match, with in_valid ignored while open
        add(1,1,0, 0,0,1,0); add(1,1,0, 0,0,1,0); add(0,1,0, 1,0,0,0);
        for (int i = 0; i < 7; i++) add(1,1,0, 1,0,0,0);
        add(0,0,0, 0,0,0,0);
        // three misses -> lockout; relock in IDLE has no effect
        add(1,1,1, 0,0,1,0); add(1,1,0, 0,0,1,0); add(1,1,0, 0,0,0,1);
        add(1,1,0, 0,0,1,1); add(1,1,0, 0,0,1,1); add(1,1,0, 0,0,0,2);
        add(1,1,0, 0,0,1,2); add(1,1,0, 0,0,1,2); add(1,1,0, 0,1,0,3);
        add(1,1,0, 0,1,0,3); add(1,1,0, 0,1,0,3); add(0,1,0, 0,1,0,3); add(0,0,1, 0,1,0,3);
        for (int i = 0; i < 11; i++) add(0,0,0, 0,1,0,3);
        add(0,0,0, 0,0,0,0);
        // unlock right after lockout, relock on third OPEN cycle
        add(1,1,0, 0,0,1,0); add(1,1,0, 0,0,1,0); add(0,1,0, 1,0,0,0);
        add(0,0,0, 1,0,0,0); add(0,0,0, 1,0,0,0); add(0,0,1, 0,0,0,0); add(0,0,0, 0,0,0,0);
        // recovery: two misses, match clears fail_cnt, one more miss
        add(1,1,0, 0,0,1,0); add(1,1,0, 0,0,1,0); add(1,1,0, 0,0,0,1);
        add(1,1,0, 0,0,1,1); add(1,1,0, 0,0,1,1); add(1,1,0, 0,0,0,2);
        add(1,1,0, 0,0,1,2); add(1,1,0, 0,0,1,2); add(0,1,0, 1,0,0,0);
        for (int i = 0; i < 7; i++) add(0,0,0, 1,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(0,1,0, 0,0,1,0); add(0,1,0, 0,0,1,0); add(0,1,0, 0,0,0,1);

        rst = 1'b1; in = 0; in_valid = 0; relock = 0; in5 = 0; v5 = 0; rl5 = 0;
        #3;
        check_all("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        check("reset out5", 8'(out5), 8'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].vld, tbl[i].rl);
            check_all($sformatf("row%0d", i), tbl[i].e_out, tbl[i].e_lock, tbl[i].e_busy, tbl[i].e_fail);
        end

        // timeout at exactly 32 idle cycles, fail_cnt untouched
        step(1,1,0); step(1,1,0);
        for (int i = 0; i < 31; i++) step(0,0,0);
        check_all("idle31", 1'b0, 1'b0, 1'b1, 2'd1);
        step(0,0,0);
        check_all("idle32", 1'b0, 1'b0, 1'b0, 2'd1);
        step(0,1,0); step(1,1,0); step(1,1,0);
        check_all("after_to_miss", 1'b0, 1'b0, 1'b0, 2'd2);
        step(0,1,0);
        check_all("leftover", 1'b0, 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 32; i++) step(0,0,0);
        check_all("leftover_to", 1'b0, 1'b0, 1'b0, 2'd2);

        // final bit arriving on the would-be timeout cycle completes the entry
        step(1,1,0); step(1,1,0);
        for (int i = 0; i < 31; i++) step(0,0,0);
        step(0,1,0);
        check_all("bit_wins", 1'b1, 1'b0, 1'b0, 2'd0);
        step(0,0,0);
        rst_pulse("rst_open");

        for (int i = 0; i < 9; i++) step(1,1,0);
        check_all("lock_again", 1'b0, 1'b1, 1'b0, 2'd3);
        step(0,0,0); step(0,0,0);
        rst_pulse("rst_lock");

        step(1,1,0);
        check_all("entry_pend", 1'b0, 1'b0, 1'b1, 2'd0);
        rst_pulse("rst_entry");

        // 5-bit variant
        step5(1,1); step5(0,1); step5(1,1); step5(1,1);
        check("c5 busy", 8'(busy5), 8'd1);
        check("c5 out early", 8'(out5), 8'd0);
        step5(0,1);
        check("c5 out", 8'(out5), 8'd1);
        check("c5 busy done", 8'(busy5), 8'd0);
        step5(0,0);
        check("c5 out hold", 8'(out5), 8'd1);
        step5(0,0);
        check("c5 out drop", 8'(out5), 8'd0);
        step5(1,1); step5(0,1); step5(1,1); step5(1,1); step5(1,1);
        check("c5 miss out", 8'(out5), 8'd0);
        check("c5 miss fail", 8'(fail5), 8'd1);
        check("c5 lockout", 8'(lockout5), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
